// File: rtl/program_loader.sv
// Boot-time program loader: accepts a framed image (length, payload, checksum)
// over a valid/ready byte stream, writes the payload to memory, then releases
// the CPU via cpu_run.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 single-cycle load request (ignored while busy)
//   in_data/in_valid      stream byte and its valid
//   in_ready              loader can take a byte this cycle
//   mem_addr/wdata/we     registered memory write port (one we pulse per byte)
//   mem_rdata             readback data, one cycle after mem_addr
//   busy/done/err         load in progress / last load ok / last load failed
//   err_code              01 bad length, 10 checksum, 11 readback, 00 none
//   cpu_run               processor release
//
// Optional feature macro: LOADER_VERIFY_EN (readback verify before release).
module program_loader #(
    parameter int              ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              cpu_run
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
`ifdef LOADER_VERIFY_EN
        S_VERIFY,
`endif
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [32:0] SPACE = 33'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [7:0]        rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sum_q, sum_d;
    logic [1:0]        code_q, code_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;

    logic              accept;
    logic              bad_len;
    logic [32:0]       len_end;

    // Last payload byte lands at BASE_ADDR + L - 1, so BASE_ADDR + L may
    // equal but not exceed the size of the address space.
    assign len_end = 33'(BASE_ADDR) + 33'(in_data);
    assign bad_len = (in_data == 8'h00) || (len_end > SPACE);
    assign accept  = in_valid && in_ready;

`ifdef LOADER_VERIFY_EN
    logic [7:0] len_q, len_d;
    logic [7:0] vcnt_q, vcnt_d;
    logic       pend_q, pend_d;
    logic [7:0] vsum_q, vsum_d;
    logic [7:0] vsum_nx;

    assign vsum_nx = vsum_q + mem_rdata;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        code_d  = code_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
`ifdef LOADER_VERIFY_EN
        len_d   = len_q;
        vcnt_d  = vcnt_q;
        pend_d  = 1'b0;
        vsum_d  = vsum_q;
`endif
        unique case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    code_d  = 2'b00;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (bad_len) begin
                        state_d = S_ERR;
                        code_d  = 2'b01;
                    end else begin
                        rem_d   = in_data;
                        addr_d  = BASE_ADDR;
                        sum_d   = 8'h00;
                        state_d = S_DATA;
`ifdef LOADER_VERIFY_EN
                        len_d   = in_data;
`endif
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    maddr_d = addr_q;
                    wdata_d = in_data;
                    we_d    = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    sum_d   = sum_q + in_data;
                    rem_d   = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == sum_q) begin
`ifdef LOADER_VERIFY_EN
                        state_d = S_VERIFY;
                        maddr_d = BASE_ADDR;
                        vcnt_d  = len_q;
                        vsum_d  = 8'h00;
`else
                        state_d = S_RUN;
`endif
                    end else begin
                        state_d = S_ERR;
                        code_d  = 2'b10;
                    end
                end
            end
`ifdef LOADER_VERIFY_EN
            // vcnt counts addresses still to present; pend marks that the
            // address shown this cycle returns data on the next edge.
            S_VERIFY: begin
                if (vcnt_q != 8'd0) begin
                    pend_d  = 1'b1;
                    vcnt_d  = vcnt_q - 8'd1;
                    maddr_d = maddr_q + ADDR_W'(1);
                end
                if (pend_q) begin
                    vsum_d = vsum_nx;
                    if (vcnt_q == 8'd0) begin
                        if (vsum_nx == sum_q) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_ERR;
                            code_d  = 2'b11;
                        end
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
            code_q  <= '0;
            maddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
`ifdef LOADER_VERIFY_EN
            len_q   <= '0;
            vcnt_q  <= '0;
            pend_q  <= 1'b0;
            vsum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            code_q  <= code_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
`ifdef LOADER_VERIFY_EN
            len_q   <= len_d;
            vcnt_q  <= vcnt_d;
            pend_q  <= pend_d;
            vsum_q  <= vsum_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_LEN) || (state_q == S_DATA) ||
                       (state_q == S_CSUM);
`ifdef LOADER_VERIFY_EN
    assign busy      = in_ready || (state_q == S_VERIFY);
`else
    assign busy      = in_ready;
`endif
    assign done      = (state_q == S_RUN);
    assign cpu_run   = (state_q == S_RUN);
    assign err       = (state_q == S_ERR);
    assign err_code  = code_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage that sits directly upstream of the 8-bit accumulator processor and its unified memory.
- Receives a framed program image as a byte stream over a valid/ready handshake. Frame format: length byte, then payload bytes, then an 8-bit checksum byte.
- Writes the payload into memory starting at a base address.
- Asserts cpu_run only after the image is accepted. The processor clock gating and PC release key off cpu_run.

Parameters:
- BASE_ADDR, 8'h00, memory address of the first payload byte; the first instruction fetched after release.
- ADDR_W, 8, memory address width; the address space holds 2**ADDR_W bytes.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; sampled on rising edge.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid; the producer holds in_data stable until it is accepted.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_addr  output  ADDR_W  memory write/read address.
- mem_wdata  output  8  memory write data.
- mem_we  output  1  memory write enable; one cycle per payload byte.
- mem_rdata  input  8  memory read data, valid one cycle after mem_addr is presented; used only when LOADER_VERIFY_EN is defined.
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- err  output  1  last load failed.
- err_code  output  2  01 = bad length, 10 = checksum mismatch, 11 = readback mismatch, 00 = none.
- cpu_run  output  1  processor release.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE immediately.
  - All outputs go to 0, including an in-flight mem_we and cpu_run.
  - Payload bytes already written to memory are not undone.
- Handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_valid while in_ready is low is ignored; no bytes are dropped or duplicated.
- States: IDLE, LEN, DATA, CSUM, VERIFY (only with LOADER_VERIFY_EN), RUN, ERR.
- busy is 1 exactly in LEN, DATA, CSUM and VERIFY.
- in_ready is 1 exactly in LEN, DATA and CSUM.
- IDLE:
  - start moves to LEN.
  - On that move, done, err, err_code and cpu_run are cleared.
- LEN, on an accepted byte L:
  - L == 0, or BASE_ADDR + L > 2**ADDR_W: go to ERR with code 01.
  - Otherwise: remaining = L, addr = BASE_ADDR, sum = 0, go to DATA.
- DATA, on an accepted byte B:
  - mem_addr = addr, mem_wdata = B, and mem_we = 1 are registered outputs, so mem_we is high for exactly the following cycle.
  - addr increments and sum = (sum + B) mod 256.
  - remaining decrements; when it reaches 0, go to CSUM.
  - Back-to-back bytes give consecutive one-cycle mem_we pulses.
- CSUM, on an accepted byte C:
  - C == sum: go to VERIFY if the macro is defined, otherwise go to RUN.
  - C != sum: go to ERR with code 10.
- RUN:
  - cpu_run = 1 and done = 1, asserted the cycle after the final accepting edge.
  - Held until start.
  - start in RUN behaves as start in IDLE: cpu_run drops at that edge and the state goes to LEN (reload).
- ERR:
  - err = 1 with err_code held; cpu_run = 0.
  - start behaves as in IDLE.
- start while busy is ignored.
- Address arithmetic is ADDR_W bits; the length check guarantees addr never wraps.
- mem_we is never asserted outside DATA-accepted bytes.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- Defined:
  - After a checksum pass, enter VERIFY and read back L bytes from BASE_ADDR upward, presenting one address per cycle with mem_we = 0.
  - Compare each mem_rdata one cycle later against a re-accumulated running checksum. Readback sum != accepted sum gives ERR with code 11; otherwise go to RUN.
  - This adds L+1 cycles before cpu_run.
- Not defined:
  - VERIFY does not exist and mem_rdata is unconnected/ignored.
  - Code 11 is never produced.
  - CSUM pass goes to RUN directly.

Test Plan:
- Good load: reset, start, stream 03, 21, 42, 03, 66 with in_valid held -> writes 21@00, 42@01, 03@02, each mem_we one cycle; cpu_run = 1, done = 1, err = 0 after the checksum edge (plus 4 cycles if verify is enabled).
- Bad checksum: stream 02, 10, 20, 31 -> err = 1, err_code = 10, cpu_run = 0; two writes observed.
- Bad length: stream 00 -> err = 1, err_code = 01, no mem_we; then stream 01, 7F, 7F -> cpu_run = 1.
- Backpressure/gaps: same image as the good load with random in_valid gaps, and start pulsed mid-load -> identical writes and result; the mid-load start has no effect.
- Reset mid-DATA: after one payload byte, pulse rst_n low mid-cycle -> all outputs 0 asynchronously; then a fresh good load succeeds.
- Verify mismatch (macro defined): memory model corrupts address 01 -> err_code = 11, cpu_run = 0.
